dynamic_bpredictor: RTL and testbench
=====================================

DYNAMIC_BPREDICTOR -- requirements
Module: dynamic_bpredictor

Interface
REQ-001 SHALL have parameter BHT_DEPTH, default 64, number of branch history table (BHT) entries; power of two, 4..1024.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port aresetn  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port i_pc  input  XLEN  PC of the instruction being fetched.
REQ-005 SHALL have port i_stall  input  1  fetch stall; freezes prediction registers.
REQ-006 SHALL have port i_is_op_jal  input  1  instruction is JAL.
REQ-007 SHALL have port i_is_op_branch  input  1  instruction is a conditional branch.
REQ-008 SHALL have port i_immJ  input  XLEN  sign-extended J immediate.
REQ-009 SHALL have port i_immB  input  XLEN  sign-extended B immediate.
REQ-010 SHALL have port i_instr_valid  input  1  instruction valid.
REQ-011 SHALL have port i_upd_valid  input  1  branch resolution from execute; one-cycle strobe.
REQ-012 SHALL have port i_upd_pc  input  XLEN  PC of the resolved branch.
REQ-013 SHALL have port i_upd_taken  input  1  resolved direction; 1 = taken.
REQ-014 SHALL have port o_branch_pc  output  XLEN  registered predicted target.
REQ-015 SHALL have port o_branch_taken  output  1  registered predicted direction.
REQ-016 SHALL have port o_pred_dyn  output  1  registered; 1 = direction came from a trained BHT entry.
REQ-017 SHALL have port o_flush  output  1  registered single-cycle flush on predicted taken.

Function
REQ-018 BHT index SHALL be pc[IDX_W+1:2], IDX_W = log2(BHT_DEPTH); no tags, aliasing accepted.
REQ-019 Each entry SHALL hold a valid bit and a 2-bit saturating counter: SNT=00, WNT=01, WT=10, ST=11.
REQ-020 Target SHALL be i_pc+i_immJ if JAL, else i_pc+i_immB if branch, else i_pc; XLEN-bit, wrap-around modulo 2^XLEN.
REQ-021 Direction SHALL be: JAL -> taken; branch with valid entry -> counter[1]; branch with invalid entry -> i_immB[XLEN-1] (backward taken); other -> not taken; all gated by i_instr_valid.
REQ-022 o_pred_dyn SHALL be 1 only for a valid branch hitting a valid entry.
REQ-023 When i_stall=0, o_branch_pc, o_branch_taken, o_pred_dyn SHALL load next-cycle values; when i_stall=1 they SHALL hold (latency 1 cycle).
REQ-024 o_flush SHALL assert the cycle after a taken prediction loaded with i_stall=0, and SHALL deassert the following cycle unconditionally, even if another taken prediction is loaded.
REQ-025 On i_upd_valid with valid entry: taken -> counter+1 saturating at ST; not taken -> counter-1 saturating at SNT.
REQ-026 On i_upd_valid with invalid entry: set valid; counter = WT if taken, WNT if not taken.
REQ-027 BHT updates SHALL proceed regardless of i_stall.
REQ-028 Update and lookup of the same index in one cycle: behaviour per REQ-032/033.

Reset
REQ-029 aresetn low SHALL immediately clear o_branch_pc to 0, o_branch_taken, o_pred_dyn, o_flush to 0, all BHT valid bits to 0.
REQ-030 Reset mid-operation SHALL discard pending flush and all training; counter bits need not be reset.
REQ-031 No update SHALL be applied in a cycle where aresetn is low.

Configuration
REQ-032 With DBP_UPD_BYPASS_EN defined, a same-index lookup SHALL use the post-update valid/counter value.
REQ-033 Without DBP_UPD_BYPASS_EN, a same-index lookup SHALL use the pre-update stored value; update still commits.

Structure
REQ-034 Shared package pqr5_bp_pkg SHALL hold the counter state typedef/encodings, BHT_DEPTH default, and the index-width function.
REQ-035 Sub-module bp_bht SHALL hold the valid/counter array with one combinational read and one update write port.

Verification
REQ-036 Reset, branch at pc=0x100 immB=-16 -> next cycle o_branch_taken=1, o_branch_pc=0xF0, o_pred_dyn=0, o_flush=1, then o_flush=0.
REQ-037 Two not-taken updates for pc=0x100, then lookup immB=-16 -> o_branch_taken=0, o_pred_dyn=1 (counter SNT).
REQ-038 Three taken updates pc=0x200 -> counter ST; a fourth stays ST; one not-taken -> WT, lookup predicts taken.
REQ-039 JAL at pc=0xFFFFFFF0 immJ=0x20 -> o_branch_pc=0x10, taken; back-to-back taken on next cycle -> o_flush 1 then 0.
REQ-040 i_stall=1 across taken lookup -> outputs and o_flush hold 0; i_stall=0 -> prediction appears one cycle later.
REQ-041 Same-cycle update (not taken, invalid entry) and forward-branch lookup at pc=0x300 -> with bypass o_pred_dyn=1 taken=0; without bypass o_pred_dyn=0.

Source files
------------

// File: rtl/pqr5_bp_pkg.sv
// -----------------------------------------------------------------------------
// pqr5_bp_pkg
// Shared definitions for the dynamic branch predictor:
//   - 2-bit saturating counter state encoding (ctr_e)
//   - default BHT depth and datapath width
//   - idx_width(): BHT index width for a given depth
//   - ctr_next(): training rule applied on a branch resolution
// -----------------------------------------------------------------------------
package pqr5_bp_pkg;

  localparam int unsigned BHT_DEPTH_DEF = 64;
  localparam int unsigned XLEN_DEF      = 32;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // An untrained entry is seeded weakly in the resolved direction; a trained
  // entry moves one step toward it and saturates at either end.
  function automatic ctr_e ctr_next(input logic valid, input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    if (!valid) begin
      nxt = taken ? CTR_WT : CTR_WNT;
    end else begin
      case (cur)
        CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
        CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
        CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
        CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
        default: nxt = CTR_WNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_bht.sv
// -----------------------------------------------------------------------------
// bp_bht
// Branch history table: DEPTH entries of {valid, 2-bit counter}, one
// combinational read port and one update write port.
//
// Ports:
//   clk          clock
//   aresetn      asynchronous active-low reset (clears valid bits only)
//   rd_idx_i     lookup index
//   rd_valid_o   entry valid at rd_idx_i
//   rd_ctr_o     counter at rd_idx_i
//   upd_en_i     update strobe
//   upd_idx_i    update index
//   upd_taken_i  resolved direction
//
// Build option: DBP_UPD_BYPASS_EN -- a lookup of the index being updated in
// the same cycle returns the post-update valid/counter; otherwise it returns
// the stored (pre-update) value.
// -----------------------------------------------------------------------------
module bp_bht
  import pqr5_bp_pkg::*;
#(
  parameter int unsigned DEPTH = BHT_DEPTH_DEF,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [DEPTH-1:0] valid_q;
  ctr_e             ctr_q [DEPTH];
  ctr_e             upd_ctr_d;
  logic             upd_commit;

  // Counter storage has no reset, so the reset level is folded into the
  // write enable to keep updates from landing while reset is asserted.
  assign upd_commit = upd_en_i && aresetn;

  always_comb begin
    upd_ctr_d = ctr_next(valid_q[upd_idx_i], ctr_q[upd_idx_i], upd_taken_i);
  end

  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_ctr_o   = ctr_q[rd_idx_i];
`ifdef DBP_UPD_BYPASS_EN
    if (upd_commit && (upd_idx_i == rd_idx_i)) begin
      rd_valid_o = 1'b1;
      rd_ctr_o   = upd_ctr_d;
    end
`endif
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_q <= '0;
    end else if (upd_en_i) begin
      valid_q[upd_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (upd_commit) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/dynamic_bpredictor.sv
// -----------------------------------------------------------------------------
// dynamic_bpredictor
// Fetch-stage branch predictor. JAL is always taken; conditional branches use
// an untagged BHT of 2-bit counters, falling back to backward-taken /
// forward-not-taken when the entry is untrained. Outputs are registered and
// frozen by i_stall; BHT training from execute ignores i_stall.
//
// Ports:
//   clk, aresetn            clock, asynchronous active-low reset
//   i_pc                    fetch PC
//   i_stall                 holds prediction registers
//   i_is_op_jal/_branch     instruction class
//   i_immJ, i_immB          sign-extended immediates
//   i_instr_valid           gates the predicted direction
//   i_upd_valid/_pc/_taken  branch resolution strobe from execute
//   o_branch_pc             predicted target
//   o_branch_taken          predicted direction
//   o_pred_dyn              direction came from a trained BHT entry
//   o_flush                 one-cycle pulse after a taken prediction loads
//
// Build option: DBP_UPD_BYPASS_EN (see bp_bht) selects post-update
// visibility for same-cycle same-index lookup.
// -----------------------------------------------------------------------------
module dynamic_bpredictor
  import pqr5_bp_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = BHT_DEPTH_DEF,
  parameter int unsigned XLEN      = XLEN_DEF
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_stall,
  input  logic            i_is_op_jal,
  input  logic            i_is_op_branch,
  input  logic [XLEN-1:0] i_immJ,
  input  logic [XLEN-1:0] i_immB,
  input  logic            i_instr_valid,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken,
  output logic [XLEN-1:0] o_branch_pc,
  output logic            o_branch_taken,
  output logic            o_pred_dyn,
  output logic            o_flush
);

  localparam int unsigned IDX_W = idx_width(BHT_DEPTH);

  logic [IDX_W-1:0] lkp_idx;
  logic [IDX_W-1:0] upd_idx;
  logic             rd_valid;
  logic [1:0]       rd_ctr;

  logic [XLEN-1:0]  branch_pc_d, branch_pc_q;
  logic             taken_d, taken_q;
  logic             dyn_d, dyn_q;
  logic             flush_d, flush_q;

  logic             unused_bits;

  assign lkp_idx = i_pc[IDX_W+1:2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];

  assign unused_bits = ^{i_upd_pc[1:0], i_upd_pc[XLEN-1:IDX_W+2], rd_ctr[0]};

  bp_bht #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk         (clk),
    .aresetn     (aresetn),
    .rd_idx_i    (lkp_idx),
    .rd_valid_o  (rd_valid),
    .rd_ctr_o    (rd_ctr),
    .upd_en_i    (i_upd_valid),
    .upd_idx_i   (upd_idx),
    .upd_taken_i (i_upd_taken)
  );

  always_comb begin
    branch_pc_d = i_pc;
    if (i_is_op_jal) begin
      branch_pc_d = i_pc + i_immJ;
    end else if (i_is_op_branch) begin
      branch_pc_d = i_pc + i_immB;
    end
  end

  always_comb begin
    taken_d = 1'b0;
    dyn_d   = 1'b0;
    if (i_instr_valid) begin
      if (i_is_op_jal) begin
        taken_d = 1'b1;
      end else if (i_is_op_branch) begin
        if (rd_valid) begin
          taken_d = rd_ctr[1];
          dyn_d   = 1'b1;
        end else begin
          taken_d = i_immB[XLEN-1];
        end
      end
    end
  end

  // Flush pulses for exactly one cycle: a flush already high always drops,
  // even when the next loaded prediction is also taken.
  assign flush_d = !flush_q && !i_stall && taken_d;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      branch_pc_q <= '0;
      taken_q     <= 1'b0;
      dyn_q       <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      if (!i_stall) begin
        branch_pc_q <= branch_pc_d;
        taken_q     <= taken_d;
        dyn_q       <= dyn_d;
      end
      flush_q <= flush_d;
    end
  end

  assign o_branch_pc    = branch_pc_q;
  assign o_branch_taken = taken_q;
  assign o_pred_dyn     = dyn_q;
  assign o_flush        = flush_q;

endmodule

// File: tb/tb_dynamic_bpredictor.sv
module tb_dynamic_bpredictor;

  logic        clk;
  logic        aresetn;
  logic [31:0] i_pc;
  logic        i_stall;
  logic        i_is_op_jal;
  logic        i_is_op_branch;
  logic [31:0] i_immJ;
  logic [31:0] i_immB;
  logic        i_instr_valid;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] o_branch_pc;
  logic        o_branch_taken;
  logic        o_pred_dyn;
  logic        o_flush;

  logic [34:0] obs;
  int unsigned total;
  int unsigned bad;

  // obs = {o_branch_pc, o_branch_taken, o_pred_dyn, o_flush}
  assign obs = {o_branch_pc, o_branch_taken, o_pred_dyn, o_flush};

  dynamic_bpredictor #(
    .BHT_DEPTH (64),
    .XLEN      (32)
  ) dut (
    .clk            (clk),
    .aresetn        (aresetn),
    .i_pc           (i_pc),
    .i_stall        (i_stall),
    .i_is_op_jal    (i_is_op_jal),
    .i_is_op_branch (i_is_op_branch),
    .i_immJ         (i_immJ),
    .i_immB         (i_immB),
    .i_instr_valid  (i_instr_valid),
    .i_upd_valid    (i_upd_valid),
    .i_upd_pc       (i_upd_pc),
    .i_upd_taken    (i_upd_taken),
    .o_branch_pc    (o_branch_pc),
    .o_branch_taken (o_branch_taken),
    .o_pred_dyn     (o_pred_dyn),
    .o_flush        (o_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_pc           = '0;
    i_stall        = 1'b0;
    i_is_op_jal    = 1'b0;
    i_is_op_branch = 1'b0;
    i_immJ         = '0;
    i_immB         = '0;
    i_instr_valid  = 1'b0;
    i_upd_valid    = 1'b0;
    i_upd_pc       = '0;
    i_upd_taken    = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic jal, input logic br,
                        input logic [31:0] immj, input logic [31:0] immb, input logic vld);
    i_pc           = pc;
    i_is_op_jal    = jal;
    i_is_op_branch = br;
    i_immJ         = immj;
    i_immB         = immb;
    i_instr_valid  = vld;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken);
    i_upd_valid = 1'b1;
    i_upd_pc    = pc;
    i_upd_taken = taken;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    idle();
    aresetn = 1'b0;
    #2;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    aresetn = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL reset_async got=%h exp=%h", obs, {32'h0, 3'b000});
    end
    // taken lookup and a training update while reset is held
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    upd(32'h100, 1'b1);
    tick();
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", obs, {32'h0, 3'b000});
    end
    idle();
    aresetn = 1'b1;
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    tick();
    total++;
    if (obs !== {32'h108, 3'b000}) begin
      bad++; $display("FAIL reset_no_train got=%h exp=%h", obs, {32'h108, 3'b000});
    end
  endtask

  task automatic test_static();
    do_reset();
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'hF0, 3'b101}) begin
      bad++; $display("FAIL static_bwd got=%h exp=%h", obs, {32'hF0, 3'b101});
    end
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    tick();
    total++;
    if (obs !== {32'h108, 3'b000}) begin
      bad++; $display("FAIL static_fwd got=%h exp=%h", obs, {32'h108, 3'b000});
    end
    lookup(32'h400, 1'b0, 1'b0, 32'h40, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'h400, 3'b000}) begin
      bad++; $display("FAIL static_nonbr got=%h exp=%h", obs, {32'h400, 3'b000});
    end
    lookup(32'h40, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    tick();
    total++;
    if (obs !== {32'h48, 3'b000}) begin
      bad++; $display("FAIL static_invalid got=%h exp=%h", obs, {32'h48, 3'b000});
    end
  endtask

  task automatic test_train_down();
    do_reset();
    upd(32'h100, 1'b0);
    tick();
    upd(32'h100, 1'b0);
    tick();
    idle();
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'hF0, 3'b010}) begin
      bad++; $display("FAIL train_snt got=%h exp=%h", obs, {32'hF0, 3'b010});
    end
    idle();
    upd(32'h100, 1'b0);
    tick();
    upd(32'h100, 1'b1);
    tick();
    idle();
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'hF0, 3'b010}) begin
      bad++; $display("FAIL train_snt_sat got=%h exp=%h", obs, {32'hF0, 3'b010});
    end
    lookup(32'h104, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'hF4, 3'b101}) begin
      bad++; $display("FAIL train_other_idx got=%h exp=%h", obs, {32'hF4, 3'b101});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      upd(32'h200, 1'b1);
      tick();
    end
    idle();
    lookup(32'h200, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1);
    tick();
    total++;
    if (obs !== {32'h204, 3'b111}) begin
      bad++; $display("FAIL sat_st got=%h exp=%h", obs, {32'h204, 3'b111});
    end
    idle();
    upd(32'h200, 1'b0);
    tick();
    idle();
    lookup(32'h200, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1);
    tick();
    total++;
    if (obs !== {32'h204, 3'b111}) begin
      bad++; $display("FAIL sat_wt got=%h exp=%h", obs, {32'h204, 3'b111});
    end
    idle();
    upd(32'h200, 1'b0);
    tick();
    idle();
    lookup(32'h200, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1);
    tick();
    total++;
    if (obs !== {32'h204, 3'b010}) begin
      bad++; $display("FAIL sat_wnt got=%h exp=%h", obs, {32'h204, 3'b010});
    end
    // 0x100 aliases to the same index as 0x200 in a 64-entry table
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'h4, 1'b1);
    tick();
    total++;
    if (obs !== {32'h104, 3'b010}) begin
      bad++; $display("FAIL sat_alias got=%h exp=%h", obs, {32'h104, 3'b010});
    end
  endtask

  task automatic test_jal_back_to_back();
    do_reset();
    lookup(32'hFFFFFFF0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
    tick();
    total++;
    if (obs !== {32'h10, 3'b101}) begin
      bad++; $display("FAIL jal_wrap got=%h exp=%h", obs, {32'h10, 3'b101});
    end
    tick();
    total++;
    if (obs !== {32'h10, 3'b100}) begin
      bad++; $display("FAIL jal_b2b_flush got=%h exp=%h", obs, {32'h10, 3'b100});
    end
    idle();
    tick();
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL jal_after got=%h exp=%h", obs, {32'h0, 3'b000});
    end
  endtask

  task automatic test_stall();
    do_reset();
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    i_stall = 1'b1;
    tick();
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL stall_hold1 got=%h exp=%h", obs, {32'h0, 3'b000});
    end
    tick();
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL stall_hold2 got=%h exp=%h", obs, {32'h0, 3'b000});
    end
    i_stall = 1'b0;
    tick();
    total++;
    if (obs !== {32'hF0, 3'b101}) begin
      bad++; $display("FAIL stall_release got=%h exp=%h", obs, {32'hF0, 3'b101});
    end
    // new input and a BHT update while stalled: outputs hold, training lands
    lookup(32'h500, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    upd(32'h104, 1'b0);
    i_stall = 1'b1;
    tick();
    total++;
    if (obs !== {32'hF0, 3'b100}) begin
      bad++; $display("FAIL stall_hold_taken got=%h exp=%h", obs, {32'hF0, 3'b100});
    end
    idle();
    lookup(32'h104, 1'b0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b1);
    tick();
    total++;
    if (obs !== {32'hF4, 3'b010}) begin
      bad++; $display("FAIL stall_upd got=%h exp=%h", obs, {32'hF4, 3'b010});
    end
  endtask

  task automatic test_bypass();
    do_reset();
    lookup(32'h300, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    upd(32'h300, 1'b0);
    tick();
    total++;
`ifdef DBP_UPD_BYPASS_EN
    if (obs !== {32'h308, 3'b010}) begin
      bad++; $display("FAIL bypass_nt got=%h exp=%h", obs, {32'h308, 3'b010});
    end
`else
    if (obs !== {32'h308, 3'b000}) begin
      bad++; $display("FAIL bypass_nt got=%h exp=%h", obs, {32'h308, 3'b000});
    end
`endif
    idle();
    lookup(32'h300, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    tick();
    total++;
    if (obs !== {32'h308, 3'b010}) begin
      bad++; $display("FAIL bypass_commit got=%h exp=%h", obs, {32'h308, 3'b010});
    end
    lookup(32'h304, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    upd(32'h304, 1'b1);
    tick();
    total++;
`ifdef DBP_UPD_BYPASS_EN
    if (obs !== {32'h30C, 3'b111}) begin
      bad++; $display("FAIL bypass_t got=%h exp=%h", obs, {32'h30C, 3'b111});
    end
`else
    if (obs !== {32'h30C, 3'b000}) begin
      bad++; $display("FAIL bypass_t got=%h exp=%h", obs, {32'h30C, 3'b000});
    end
`endif
    idle();
    lookup(32'h304, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    tick();
    total++;
`ifdef DBP_UPD_BYPASS_EN
    if (obs !== {32'h30C, 3'b110}) begin
      bad++; $display("FAIL bypass_t_commit got=%h exp=%h", obs, {32'h30C, 3'b110});
    end
`else
    if (obs !== {32'h30C, 3'b111}) begin
      bad++; $display("FAIL bypass_t_commit got=%h exp=%h", obs, {32'h30C, 3'b111});
    end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    upd(32'h100, 1'b1);
    tick();
    upd(32'h100, 1'b1);
    tick();
    idle();
    lookup(32'h100, 1'b0, 1'b1, 32'h0, 32'h8, 1'b1);
    tick();
    total++;
    if (obs !== {32'h108, 3'b111}) begin
      bad++; $display("FAIL midrst_trained got=%h exp=%h", obs, {32'h108, 3'b111});
    end
    #2;
    aresetn = 1'b0;
    #1;
    total++;
    if (obs !== {32'h0, 3'b000}) begin
      bad++; $display("FAIL midrst_async got=%h exp=%h", obs, {32'h0, 3'b000});
    end
    aresetn = 1'b1;
    tick();
    total++;
    if (obs !== {32'h108, 3'b000}) begin
      bad++; $display("FAIL midrst_untrained got=%h exp=%h", obs, {32'h108, 3'b000});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_static();
    test_train_down();
    test_saturate();
    test_jal_back_to_back();
    test_stall();
    test_bypass();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
